// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver (start, 8 data LSB first, stop) with mid-bit sampling.
// Optional stop-bit framing check is compiled in by defining UART_RX_FRAMING_CHECK_EN.
module uart_rx #(
  parameter int CLK_RATE  = 12000000,
  parameter int BAUD_RATE = 9600,
  parameter int CLK_DIV   = CLK_RATE / BAUD_RATE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_line,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_overrun,
  output logic       rx_frame_error
);

  localparam logic [11:0] FULL_BIT = 12'(CLK_DIV - 1);
  localparam logic [11:0] HALF_BIT = 12'(CLK_DIV / 2 - 1);

`ifdef UART_RX_FRAMING_CHECK_EN
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;
`endif

  state_t      state;
  state_t      state_next;
  logic [1:0]  sync;
  logic        line;
  logic [11:0] timer;
  logic [11:0] timer_next;
  logic [2:0]  bit_idx;
  logic [2:0]  bit_idx_next;
  logic [7:0]  shift;
  logic [7:0]  shift_next;
  logic [7:0]  data_next;
  logic        valid_next;
  logic        overrun_next;
  logic        frame_error_next;
  logic        accept;

  // Two-flop synchronizer; idle-high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], rx_line};
    end
  end

  assign line = sync[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      timer      <= 12'd0;
      bit_idx    <= 3'd0;
      shift      <= 8'h00;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      state      <= state_next;
      timer      <= timer_next;
      bit_idx    <= bit_idx_next;
      shift      <= shift_next;
      rx_data    <= data_next;
      rx_valid   <= valid_next;
      rx_overrun <= overrun_next;
    end
  end

`ifdef UART_RX_FRAMING_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_frame_error <= 1'b0;
    end else begin
      rx_frame_error <= frame_error_next;
    end
  end
`else
  assign rx_frame_error = 1'b0;
`endif

  always_comb begin
    state_next       = state;
    timer_next       = timer;
    bit_idx_next     = bit_idx;
    shift_next       = shift;
    frame_error_next = 1'b0;
    accept           = 1'b0;

    case (state)
      IDLE: begin
        if (!line) begin
          state_next = START;
          timer_next = HALF_BIT;
        end
      end

      // Mid-start-bit recheck rejects glitches shorter than half a bit.
      START: begin
        if (timer == 12'd0) begin
          if (!line) begin
            state_next   = DATA;
            timer_next   = FULL_BIT;
            bit_idx_next = 3'd0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          timer_next = timer - 12'd1;
        end
      end

      DATA: begin
        if (timer == 12'd0) begin
          shift_next[bit_idx] = line;
          timer_next          = FULL_BIT;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end else begin
          timer_next = timer - 12'd1;
        end
      end

      // Leaving at mid-stop-bit gives half a bit of slack for the next start edge.
      STOP: begin
        if (timer == 12'd0) begin
`ifdef UART_RX_FRAMING_CHECK_EN
          if (line) begin
            accept     = 1'b1;
            state_next = IDLE;
          end else begin
            frame_error_next = 1'b1;
            state_next       = WAIT_HIGH;
          end
`else
          accept     = 1'b1;
          state_next = IDLE;
`endif
        end else begin
          timer_next = timer - 12'd1;
        end
      end

`ifdef UART_RX_FRAMING_CHECK_EN
      WAIT_HIGH: begin
        if (line) begin
          state_next = IDLE;
        end
      end
`endif

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output handshake: an ack coinciding with a new byte keeps valid high and is not an overrun.
  always_comb begin
    data_next    = rx_data;
    valid_next   = rx_valid & ~rx_ack;
    overrun_next = rx_overrun;
    if (accept) begin
      data_next  = shift;
      valid_next = 1'b1;
      if (rx_valid && !rx_ack) begin
        overrun_next = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed, table-driven bench for uart_rx at CLK_DIV = 32.
// Expectations follow UART_RX_FRAMING_CHECK_EN when the same macro is defined.
module tb_uart_rx;

  localparam int CLK_DIV = 32;
  localparam int LAT_MAX = CLK_DIV / 2 + 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_line = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_overrun;
  logic       rx_frame_error;

  int total = 0;
  int bad = 0;
  int fe_pulses = 0;

  typedef struct {
    logic [7:0] data;
    logic       ack;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_overrun;
  } vec_t;

  vec_t vecs[5];

  uart_rx #(
    .CLK_RATE (3200000),
    .BAUD_RATE(100000),
    .CLK_DIV  (CLK_DIV)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_line       (rx_line),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ack        (rx_ack),
    .rx_overrun    (rx_overrun),
    .rx_frame_error(rx_frame_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_frame_error === 1'b1) fe_pulses++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ack();
    tick(1);
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
  endtask

  task automatic do_reset();
    tick(1);
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(4);
  endtask

  // Drives one frame; bit edges land at round(k*bit_len) cycles so fractional rates drift.
  task automatic apply_stimulus(input logic [7:0] d, input bit stop_low, input int stop_bits,
                                input real bit_len, output int lat);
    int   cyc;
    int   nbits;
    int   stop_cyc;
    bit   armed;
    logic v;
    cyc      = 0;
    lat      = -1;
    armed    = 1'b0;
    nbits    = 9 + stop_bits;
    stop_cyc = $rtoi(9.0 * bit_len + 0.5);
    for (int k = 0; k <= nbits; k++) begin
      while (cyc < $rtoi(k * bit_len + 0.5)) begin
        @(posedge clk);
        #1;
        cyc++;
        if (armed && lat < 0 && rx_valid === 1'b1) lat = cyc - stop_cyc;
      end
      if (k == 0) v = 1'b0;
      else if (k <= 8) v = d[k-1];
      else v = ~stop_low;
      if (k == 9) armed = (rx_valid === 1'b0);
      if (k < nbits) rx_line = v;
    end
  endtask

  initial begin
    int lat;
    int cnt;
    int fe0;
    logic [7:0] b;
    real scale;

    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h3C, 1'b1, 8'h3C, 1'b1, 1'b1};
    vecs[4] = '{8'h81, 1'b1, 8'h81, 1'b1, 1'b1};

    // Reset values
    tick(2);
    check_output("reset_data", rx_data, 8'h00);
    check_output("reset_valid", rx_valid, 1'b0);
    check_output("reset_overrun", rx_overrun, 1'b0);
    check_output("reset_fe", rx_frame_error, 1'b0);
    reset = 1'b1;
    tick(4);

    // First byte, latency from stop-bit start, then ack
    apply_stimulus(8'hA5, 1'b0, 2, CLK_DIV, lat);
    check_output("a5_data", rx_data, 8'hA5);
    check_output("a5_valid", rx_valid, 1'b1);
    total++;
    if (!(lat > 0 && lat <= LAT_MAX)) begin
      bad++;
      $display("[TB] FAIL a5_latency: got %0d cycles, expected 1..%0d", lat, LAT_MAX);
    end
    pulse_ack();
    check_output("a5_ack_clears", rx_valid, 1'b0);
    pulse_ack();
    check_output("stray_ack_valid", rx_valid, 1'b0);
    check_output("stray_ack_data", rx_data, 8'hA5);

    // Table-driven frames
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(vecs[i].data, 1'b0, 2, CLK_DIV, lat);
      check_output($sformatf("vec%0d_data", i), rx_data, vecs[i].exp_data);
      check_output($sformatf("vec%0d_valid", i), rx_valid, vecs[i].exp_valid);
      check_output($sformatf("vec%0d_overrun", i), rx_overrun, vecs[i].exp_overrun);
      if (vecs[i].ack) begin
        pulse_ack();
        check_output($sformatf("vec%0d_acked", i), rx_valid, 1'b0);
      end
    end
    do_reset();
    check_output("overrun_cleared", rx_overrun, 1'b0);

    // Short LOW glitch on idle line
    rx_line = 1'b0;
    tick(8);
    rx_line = 1'b1;
    cnt = 0;
    for (int i = 0; i < 2 * CLK_DIV; i++) begin
      tick(1);
      if (rx_valid !== 1'b0) cnt++;
    end
    check_output("glitch_no_valid", cnt, 0);
    apply_stimulus(8'h3C, 1'b0, 2, CLK_DIV, lat);
    check_output("post_glitch_data", rx_data, 8'h3C);
    check_output("post_glitch_valid", rx_valid, 1'b1);
    pulse_ack();

    // Back-to-back with no ack -> overrun
    apply_stimulus(8'h11, 1'b0, 1, CLK_DIV, lat);
    apply_stimulus(8'h22, 1'b0, 1, CLK_DIV, lat);
    check_output("b2b_data", rx_data, 8'h22);
    check_output("b2b_valid", rx_valid, 1'b1);
    check_output("b2b_overrun", rx_overrun, 1'b1);
    do_reset();

    // Ack on the same edge the second byte completes (edge CLK_DIV*9 + CLK_DIV/2 + 3)
    apply_stimulus(8'h11, 1'b0, 1, CLK_DIV, lat);
    fork
      apply_stimulus(8'h22, 1'b0, 1, CLK_DIV, lat);
      begin
        repeat (CLK_DIV * 9 + CLK_DIV / 2 + 2) @(posedge clk);
        #1;
        rx_ack = 1'b1;
        @(posedge clk);
        #1;
        rx_ack = 1'b0;
      end
    join
    check_output("coinc_data", rx_data, 8'h22);
    check_output("coinc_valid", rx_valid, 1'b1);
    check_output("coinc_overrun", rx_overrun, 1'b0);
    pulse_ack();
    do_reset();

    // Stop bit LOW followed by a long break
    fe0 = fe_pulses;
    apply_stimulus(8'h55, 1'b1, 1, CLK_DIV, lat);
`ifdef UART_RX_FRAMING_CHECK_EN
    check_output("bad_stop_valid", rx_valid, 1'b0);
    check_output("bad_stop_data", rx_data, 8'h00);
    check_output("bad_stop_fe", fe_pulses - fe0, 1);
`else
    check_output("bad_stop_data", rx_data, 8'h55);
    check_output("bad_stop_valid", rx_valid, 1'b1);
    check_output("bad_stop_fe", fe_pulses - fe0, 0);
`endif
    tick(20 * CLK_DIV);
    rx_line = 1'b1;
    tick(12 * CLK_DIV);
`ifdef UART_RX_FRAMING_CHECK_EN
    check_output("break_fe_single", fe_pulses - fe0, 1);
    check_output("break_valid", rx_valid, 1'b0);
`else
    pulse_ack();
    check_output("break_acked", rx_valid, 1'b0);
`endif
    apply_stimulus(8'h0F, 1'b0, 2, CLK_DIV, lat);
    check_output("after_break_data", rx_data, 8'h0F);
    check_output("after_break_valid", rx_valid, 1'b1);
`ifdef UART_RX_FRAMING_CHECK_EN
    check_output("after_break_overrun", rx_overrun, 1'b0);
`endif
    do_reset();

    // Reset asserted mid-frame during data bit 4
    apply_stimulus(8'h5A, 1'b0, 2, CLK_DIV, lat);
    apply_stimulus(8'h5A, 1'b0, 2, CLK_DIV, lat);
    check_output("pre_reset_overrun", rx_overrun, 1'b1);
    fork
      apply_stimulus(8'hAB, 1'b0, 2, CLK_DIV, lat);
      begin
        repeat (5 * CLK_DIV + CLK_DIV / 2) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_output("midreset_data", rx_data, 8'h00);
        check_output("midreset_valid", rx_valid, 1'b0);
        check_output("midreset_overrun", rx_overrun, 1'b0);
        check_output("midreset_fe", rx_frame_error, 1'b0);
      end
    join
    tick(2);
    reset = 1'b1;
    tick(3);
    apply_stimulus(8'hFF, 1'b0, 2, CLK_DIV, lat);
    check_output("post_reset_data", rx_data, 8'hFF);
    check_output("post_reset_valid", rx_valid, 1'b1);
    check_output("post_reset_overrun", rx_overrun, 1'b0);
    do_reset();

    // Transmitter rate offset of +2% then -2%, one stop bit, back-to-back
    fe0 = fe_pulses;
    for (int s = 0; s < 2; s++) begin
      scale = (s == 0) ? 1.02 : 0.98;
      for (int i = 0; i < 64; i++) begin
        b = (s == 0) ? 8'(i) : 8'(8'hC0 + i);
        apply_stimulus(b, 1'b0, 1, CLK_DIV * scale, lat);
        check_output($sformatf("rate%0d_byte%0d", s, i), {rx_valid, rx_data}, {1'b1, b});
        pulse_ack();
      end
    end
    check_output("rate_overrun", rx_overrun, 1'b0);
    check_output("rate_fe", fe_pulses - fe0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
